// File: rtl/ram512_bist_if.sv
// ram512_bist_if : control/status and RAM512 port bundle for ram512_bist
// rev 1.0
`default_nettype none

interface ram512_bist_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 16
);
  logic                     start;
  logic [DATA_WIDTH-1:0]    seed;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [ADDRESS_WIDTH:0]   err_count;
  logic [ADDRESS_WIDTH-1:0] first_err_addr;
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0]    ram_in;
  logic                     ram_load;
  logic [DATA_WIDTH-1:0]    ram_out;

  // master: the controller side that requests passes and owns the RAM
  modport master (
    output start, seed, ram_out,
    input  busy, done, pass, err_count, first_err_addr, ram_address, ram_in, ram_load
  );

  modport slave (
    input  start, seed, ram_out,
    output busy, done, pass, err_count, first_err_addr, ram_address, ram_in, ram_load
  );
endinterface

`default_nettype wire

// File: rtl/ram512_bist.sv
// ram512_bist : write seed+address pattern over the whole RAM, read back and count mismatches
// rev 1.0
`default_nettype none

module ram512_bist #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  ram512_bist_if.slave    bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    READ_SET = 3'd2,
    READ_CHK = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic [DATA_WIDTH-1:0]    seed_q, seed_next;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_next;
  logic [ADDRESS_WIDTH:0]   err_q, err_next;
  logic [ADDRESS_WIDTH-1:0] first_q, first_next;
  logic                     load_q, load_next;
  logic                     busy_q, busy_next;
  logic                     done_q, done_next;
  logic                     pass_q, pass_next;
  logic [DATA_WIDTH-1:0]    pattern;

  // The same word serves as write data and as the read-back reference.
  assign pattern = seed_q + DATA_WIDTH'(addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      seed_q  <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_next;
      seed_q  <= seed_next;
      addr_q  <= addr_next;
      err_q   <= err_next;
      first_q <= first_next;
      load_q  <= load_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
      pass_q  <= pass_next;
    end
  end

  always_comb begin
    state_next = state;
    seed_next  = seed_q;
    addr_next  = addr_q;
    err_next   = err_q;
    first_next = first_q;
    load_next  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          seed_next  = bus.seed;
          err_next   = '0;
          first_next = '0;
          addr_next  = '0;
          load_next  = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_next  = '0;
          state_next = READ_SET;
        end else begin
          addr_next = addr_q + 1'b1;
          load_next = 1'b1;
        end
      end
      READ_SET: state_next = READ_CHK;
      READ_CHK: begin
        if (bus.ram_out != pattern) begin
          err_next = err_q + 1'b1;
          if (err_q == '0) first_next = addr_q;
        end
        if (addr_q == LAST_ADDR) begin
          state_next = DONE;
        end else begin
          addr_next  = addr_q + 1'b1;
          state_next = READ_SET;
        end
      end
      default: state_next = IDLE;
    endcase

    // Status flags are decoded from the next state so they register with it.
    busy_next = (state_next == WRITE) || (state_next == READ_SET) || (state_next == READ_CHK);
    done_next = (state_next == DONE);
    pass_next = done_next && (err_next == '0);
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_addr = first_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_load       = load_q;
  assign bus.ram_in         = pattern;

endmodule

`default_nettype wire

// File: tb/tb_ram512_bist.sv
// tb_ram512_bist : directed passes against a behavioural RAM512 with a done-triggered scoreboard
// rev 1.0
`default_nettype none

module tb_ram512_bist;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram512_bist_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram512_bist #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem     [0:511];
  logic          corrupt [0:511];

  always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;

  // Injected faults flip bit 0 so the word can never match by accident.
  assign bus.ram_out = corrupt[bus.ram_address] ? (mem[bus.ram_address] ^ 16'h0001)
                                                : mem[bus.ram_address];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic pass;
    int   errc;
    int   ferr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int            start_cyc = 0;
  logic [DW-1:0] exp_seed  = '0;
  int            wr_idx    = 0;
  logic [DW-1:0] cap0, cap1, cap511;

  // Write monitor: every write must follow the latched seed and the address order.
  always @(negedge clk) begin
    if (!reset && bus.ram_load) begin
      check("wr_addr", 32'(bus.ram_address), 32'(wr_idx));
      check("wr_data", 32'(bus.ram_in), 32'(16'(exp_seed + wr_idx[15:0])));
      if (wr_idx == 0)   cap0   = bus.ram_in;
      if (wr_idx == 1)   cap1   = bus.ram_in;
      if (wr_idx == 511) cap511 = bus.ram_in;
      wr_idx++;
    end
  end

  // Result monitor: each rising done consumes one scoreboard entry.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pass",           32'(bus.pass), 32'(e.pass));
        check("err_count",      32'(bus.err_count), 32'(e.errc));
        check("first_err_addr", 32'(bus.first_err_addr), 32'(e.ferr));
        check("done_latency",   32'(cyc - start_cyc + 1), 32'd1537);
        check("busy_in_done",   32'(bus.busy), 32'd0);
        check("load_in_done",   32'(bus.ram_load), 32'd0);
      end
    end
    done_prev = bus.done;
  end

  // The start-sampling edge counts as edge 1 of the 1537.
  task automatic do_start(input logic [DW-1:0] s);
    @(negedge clk);
    bus.seed  = s;
    bus.start = 1'b1;
    exp_seed  = s;
    wr_idx    = 0;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
    bus.seed  = ~s;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check({name, "_timeout"}, 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_pass"},  32'(bus.pass), 32'd0);
    check({tag, "_err"},   32'(bus.err_count), 32'd0);
    check({tag, "_ferr"},  32'(bus.first_err_addr), 32'd0);
    check({tag, "_addr"},  32'(bus.ram_address), 32'd0);
    check({tag, "_load"},  32'(bus.ram_load), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_load;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = '0;
      corrupt[i] = 1'b0;
    end
    bus.start = 1'b0;
    bus.seed  = '0;

    // Reset overrides a simultaneous start.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.seed  = 16'h7777;
    @(negedge clk);
    bus.start = 1'b0;
    check_idle("reset");
    reset = 1'b0;

    // Healthy pass, seed 5A5A.
    sb.push_back('{1'b1, 0, 0});
    do_start(16'h5A5A);
    check("first_busy", 32'(bus.busy), 32'd1);
    check("first_load", 32'(bus.ram_load), 32'd1);
    check("first_addr", 32'(bus.ram_address), 32'd0);
    check("first_in",   32'(bus.ram_in), 32'h5A5A);
    wait_done("p5a5a");
    check("w0_5a5a",   32'(cap0),   32'h5A5A);
    check("w511_5a5a", 32'(cap511), 32'h5C59);

    // Wrap-around of the pattern.
    sb.push_back('{1'b1, 0, 0});
    do_start(16'hFFFF);
    wait_done("pffff");
    check("w1_ffff", 32'(cap1), 32'h0000);

    // Two corrupted read words.
    corrupt[7]   = 1'b1;
    corrupt[300] = 1'b1;
    sb.push_back('{1'b0, 2, 7});
    do_start(16'h1234);
    wait_done("pcorrupt");
    corrupt[7]   = 1'b0;
    corrupt[300] = 1'b0;

    // start and seed change mid-write must be ignored.
    sb.push_back('{1'b1, 0, 0});
    do_start(16'h0100);
    n = 0;
    while (!(bus.ram_load && bus.ram_address == 9'd100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_wr100", 32'(bus.ram_address), 32'd100);
    bus.start = 1'b1;
    bus.seed  = 16'hBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("pignore");

    // Start from DONE restarts at address 0.
    check("done_before_restart", 32'(bus.done), 32'd1);
    do_start(16'h00AA);
    check("restart_done", 32'(bus.done), 32'd0);
    check("restart_pass", 32'(bus.pass), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_addr", 32'(bus.ram_address), 32'd0);
    check("restart_in",   32'(bus.ram_in), 32'h00AA);

    // Abort with reset at read address 200.
    n = 0;
    while (!(bus.busy && !bus.ram_load && bus.ram_address == 9'd200) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_rd200", 32'(bus.ram_address), 32'd200);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("abort");
    @(negedge clk);
    reset = 1'b0;
    seen_load = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ram_load) seen_load = 1'b1;
    end
    check("no_write_after_abort", 32'(seen_load), 32'd0);

    // Fresh pass after the abort.
    sb.push_back('{1'b1, 0, 0});
    do_start(16'h0001);
    wait_done("pfresh");

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
